// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control types for the core pipeline controller.
// Holds the forwarding-select encoding seen by the EX operand muxes and
// the states of the data-memory handshake FSM.
package ctrl_pkg;

    // EX operand source: register file, EX/MEM result, or MEM/WB result
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Data-memory handshake: RUN is idle or zero-wait, WAIT holds a pending access
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: forwarding select for a single EX operand.
// The youngest producer (EX/MEM) wins over MEM/WB. A load in EX/MEM has no
// data yet, so it never forwards. Register 0 is hard-wired and never forwarded.
import ctrl_pkg::*;

module fwd_unit #(
    parameter int REG_SELECT = 5
) (
    input  logic [REG_SELECT-1:0] src_sel,
    input  logic [REG_SELECT-1:0] mem_rd,
    input  logic                  mem_is_write,
    input  logic                  mem_is_load,
    input  logic [REG_SELECT-1:0] wb_rd,
    input  logic                  wb_is_write,
    output fwd_sel_e              fwd_sel
);

    function automatic logic reg_match(input logic [REG_SELECT-1:0] x,
                                       input logic [REG_SELECT-1:0] y);
        return (x == y) && (x != '0);
    endfunction

    // Pick the most recent non-load producer of src_sel
    always_comb begin
        fwd_sel = FWD_REG;
        if (mem_is_write && !mem_is_load && reg_match(mem_rd, src_sel)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_is_write && reg_match(wb_rd, src_sel)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline controller for the 5-stage core.
// Generates per-stage enable/flush/bubble controls for pipe_0..pipe_3,
// EX forwarding selects, the data-memory request, and a saturating count
// of cycles in which the PC did not advance.
import ctrl_pkg::*;

module hazard_ctrl #(
    parameter int REG_SELECT = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_SELECT-1:0] id_rs1,
    input  logic [REG_SELECT-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  id_is_branch,
    input  logic                  id_branch_taken,
    input  logic [REG_SELECT-1:0] ex_rs1,
    input  logic [REG_SELECT-1:0] ex_rs2,
    input  logic [REG_SELECT-1:0] ex_rd,
    input  logic                  ex_is_write,
    input  logic                  ex_is_load,
    input  logic [REG_SELECT-1:0] mem_rd,
    input  logic                  mem_is_write,
    input  logic                  mem_is_load,
    input  logic                  mem_is_store,
    input  logic [REG_SELECT-1:0] wb_rd,
    input  logic                  wb_is_write,
    input  logic                  dmem_ready,
    output logic                  dmem_req,
    output logic                  pc_en,
    output logic                  en_0,
    output logic                  flush_0,
    output logic                  en_1,
    output logic                  bubble_1,
    output logic                  en_2,
    output logic                  en_3,
    output fwd_sel_e              fwd_a,
    output fwd_sel_e              fwd_b,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    function automatic logic reg_match(input logic [REG_SELECT-1:0] x,
                                       input logic [REG_SELECT-1:0] y);
        return (x == y) && (x != '0);
    endfunction

    hz_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    fwd_sel_e fwd_a_raw;
    fwd_sel_e fwd_b_raw;

    logic id_reads_ex_rd;
    logic id_reads_mem_rd;
    logic load_use;
    logic br_haz;
    logic stall;
    logic mem_op;
    logic freeze;

    fwd_unit #(.REG_SELECT(REG_SELECT)) u_fwd_a (
        .src_sel      (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_is_write (mem_is_write),
        .mem_is_load  (mem_is_load),
        .wb_rd        (wb_rd),
        .wb_is_write  (wb_is_write),
        .fwd_sel      (fwd_a_raw)
    );

    fwd_unit #(.REG_SELECT(REG_SELECT)) u_fwd_b (
        .src_sel      (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_is_write (mem_is_write),
        .mem_is_load  (mem_is_load),
        .wb_rd        (wb_rd),
        .wb_is_write  (wb_is_write),
        .fwd_sel      (fwd_b_raw)
    );

    // Hazard detection: load-use in EX, and branch operands not yet available in decode
    always_comb begin
        id_reads_ex_rd  = (id_uses_rs1 && reg_match(ex_rd, id_rs1)) ||
                          (id_uses_rs2 && reg_match(ex_rd, id_rs2));
        id_reads_mem_rd = (id_uses_rs1 && reg_match(mem_rd, id_rs1)) ||
                          (id_uses_rs2 && reg_match(mem_rd, id_rs2));
        load_use        = ex_is_load && id_reads_ex_rd;
        br_haz          = id_is_branch &&
                          ((ex_is_write && id_reads_ex_rd) || (mem_is_load && id_reads_mem_rd));
        stall           = load_use || br_haz;
        mem_op          = mem_is_load || mem_is_store;
        dmem_req        = rst && (((state_q == RUN) && mem_op) || (state_q == WAIT));
        freeze          = dmem_req && !dmem_ready;
    end

    // State register for the memory FSM and the stall counter
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        stall_cnt_q <= stall_cnt_d;
    end

    // Next state: enter WAIT on an unfinished access, leave once memory answers
    always_comb begin
        state_d = state_q;
        if (!rst) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN:     if (freeze)     state_d = WAIT;
                WAIT:    if (dmem_ready) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Pipeline controls in priority order: reset, freeze, stall, taken branch, normal
    always_comb begin
        pc_en    = 1'b0;
        en_0     = 1'b0;
        flush_0  = 1'b0;
        en_1     = 1'b0;
        bubble_1 = 1'b0;
        en_2     = 1'b0;
        en_3     = 1'b0;
        fwd_a    = FWD_REG;
        fwd_b    = FWD_REG;
        if (rst) begin
            fwd_a = fwd_a_raw;
            fwd_b = fwd_b_raw;
            if (freeze) begin
                pc_en = 1'b0;
            end else if (stall) begin
                en_1     = 1'b1;
                bubble_1 = 1'b1;
                en_2     = 1'b1;
                en_3     = 1'b1;
            end else if (id_is_branch && id_branch_taken) begin
                pc_en   = 1'b1;
                flush_0 = 1'b1;
                en_1    = 1'b1;
                en_2    = 1'b1;
                en_3    = 1'b1;
            end else begin
                pc_en = 1'b1;
                en_0  = 1'b1;
                en_1  = 1'b1;
                en_2  = 1'b1;
                en_3  = 1'b1;
            end
        end
    end

    // Stall counter: count cycles where the PC holds, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!rst) begin
            stall_cnt_d = '0;
        end else if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
